// File: rtl/seq_mem_d2_drain.sv
// Drain engine for a seq_mem_d2: walks the array row-major over the sequential read
// port and streams words through a 2-entry valid/ready buffer. Option: SEQ_MEM_DRAIN_TIMEOUT_EN.
module seq_mem_d2_drain #(
    parameter int D0_SIZE     = 8,
    parameter int D1_SIZE     = 8,
    parameter int D0_IDX_SIZE = 4,
    parameter int D1_IDX_SIZE = 4,
    parameter int WIDTH       = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    output logic                   done,
    output logic [D0_IDX_SIZE-1:0] mem_addr0,
    output logic [D1_IDX_SIZE-1:0] mem_addr1,
    output logic                   mem_read_en,
    input  logic [WIDTH-1:0]       mem_read_data,
    input  logic                   mem_read_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last
`ifdef SEQ_MEM_DRAIN_TIMEOUT_EN
    ,
    output logic                   err
`endif
);

    if (D0_SIZE < 1 || D1_SIZE < 1 || TIMEOUT < 1) begin : g_param_chk
        $error("seq_mem_d2_drain: D0_SIZE, D1_SIZE and TIMEOUT must be >= 1");
    end

    localparam logic [D0_IDX_SIZE-1:0] LAST_ROW = D0_IDX_SIZE'(D0_SIZE - 1);
    localparam logic [D1_IDX_SIZE-1:0] LAST_COL = D1_IDX_SIZE'(D1_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                   r_state, w_state_nxt;
    logic [D0_IDX_SIZE-1:0]   r_row;
    logic [D1_IDX_SIZE-1:0]   r_col;
    logic                     r_pending;
    logic                     r_pend_last;
    logic [1:0]               r_count;
    logic [1:0][WIDTH-1:0]    r_data;
    logic [1:0]               r_last;
    logic                     r_rd, r_wr;

    logic                     w_pop, w_push, w_issue, w_room, w_fin_addr, w_tmo;
    logic [1:0]               w_cnt_nxt;

    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_data[r_rd];
    assign out_last   = r_last[r_rd];
    assign mem_addr0  = r_row;
    assign mem_addr1  = r_col;
    assign mem_read_en = w_issue;

    assign w_pop      = out_valid & out_ready;
    assign w_push     = mem_read_done & r_pending & ((r_state == S_RUN) | (r_state == S_FLUSH));
    assign w_fin_addr = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_cnt_nxt  = r_count + {1'b0, w_push} - {1'b0, w_pop};
    // Room counts the in-flight read as occupied so its word always has a slot.
    assign w_room     = ({1'b0, r_count} + {2'b00, r_pending}) < (3'd2 + {2'b00, w_pop});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: if (go) w_state_nxt = S_RUN;
            S_RUN: begin
                w_issue = w_room && (!r_pending || mem_read_done);
                if (w_issue && w_fin_addr) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: if (!(r_pending && !w_push) && w_cnt_nxt == 2'd0) w_state_nxt = S_DONE;
            S_DONE: begin
                done = go;
                if (!go) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_tmo) w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row       <= '0;
            r_col       <= '0;
            r_pending   <= 1'b0;
            r_pend_last <= 1'b0;
            r_count     <= 2'd0;
            r_data      <= '0;
            r_last      <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
        end else if (r_state == S_IDLE && go) begin
            r_row     <= '0;
            r_col     <= '0;
            r_pending <= 1'b0;
            r_count   <= 2'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
        end else if (w_tmo) begin
            r_pending <= 1'b0;
            r_count   <= 2'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pend_last <= w_fin_addr;
                // The pointer parks on the final element; IDLE reloads it.
                if (!w_fin_addr) begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + D0_IDX_SIZE'(1);
                    end else begin
                        r_col <= r_col + D1_IDX_SIZE'(1);
                    end
                end
            end
            r_pending <= w_issue | (r_pending & ~w_push);
            if (w_push) begin
                r_data[r_wr] <= mem_read_data;
                r_last[r_wr] <= r_pend_last;
                r_wr         <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_count <= w_cnt_nxt;
        end
    end

`ifdef SEQ_MEM_DRAIN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Fires on the TIMEOUT-th cycle of an unanswered read.
    assign w_tmo = r_pending && !mem_read_done && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign err   = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (!r_pending || mem_read_done) r_tmo_cnt <= '0;
            else                             r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_tmo) r_err <= 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mem_d2_drain.sv
// Bench for seq_mem_d2_drain: 2x3 memory model with variable latency, a stream
// scoreboard and occupancy/stability monitors, randomized data and back-pressure.
module tb_seq_mem_d2_drain;
    localparam int D0 = 2;
    localparam int D1 = 3;
    localparam int N  = D0 * D1;
    localparam int W  = 32;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic         done;
    logic [3:0]   mem_addr0, mem_addr1;
    logic         mem_read_en;
    logic [W-1:0] mem_read_data = '0;
    logic         mem_read_done = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_last;
`ifdef SEQ_MEM_DRAIN_TIMEOUT_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    seq_mem_d2_drain #(.D0_SIZE(D0), .D1_SIZE(D1), .D0_IDX_SIZE(4), .D1_IDX_SIZE(4),
                       .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .go(go), .done(done),
        .mem_addr0(mem_addr0), .mem_addr1(mem_addr1), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data), .mem_read_done(mem_read_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef SEQ_MEM_DRAIN_TIMEOUT_EN
        , .err(err)
`endif
    );

    int cmp = 0, mism = 0, cyc = 0;
    logic [W-1:0] mem_arr [N];
    logic [W-1:0] exp_d[$], got_d[$];
    bit           exp_l[$], got_l[$];

    // memory model
    int lat = 1, cd = 0, mem_viol = 0;
    bit mute = 0, pbusy = 0, en_s;
    logic [3:0] a0_s, a1_s;
    logic [W-1:0] pdata = '0;
    always @(posedge clk) begin
        en_s = mem_read_en; a0_s = mem_addr0; a1_s = mem_addr1;
        #1;
        mem_read_done = 1'b0;
        mem_read_data = $urandom;
        if (en_s) begin
            if (pbusy) mem_viol++;
            if (int'(a0_s) >= D0 || int'(a1_s) >= D1) mem_viol++;
            else pdata = mem_arr[int'(a0_s) * D1 + int'(a1_s)];
            pbusy = 1; cd = lat;
        end
        if (mute) pbusy = 0;
        if (pbusy) begin
            cd--;
            if (cd == 0) begin mem_read_done = 1'b1; mem_read_data = pdata; pbusy = 0; end
        end
    end

    // consumer ready: 0 = always, 1 = 1,0,0 repeating, 2 = random
    int rmode = 0, rcnt = 0;
    always @(posedge clk) begin
        #1;
        rcnt++;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // stream monitor: occupancy model, stability, scoreboard capture
    int m_occ = 0, m_pend = 0, cap_viol = 0, stab_viol = 0, vld_viol = 0, last_pop_cyc = -1;
    bit have_prev = 0, m_pop;
    logic [W-1:0] prev_d;
    logic prev_l;
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_occ = 0; m_pend = 0; have_prev = 0;
        end else begin
            m_pop = out_valid && out_ready;
            if (out_valid !== (m_occ > 0)) vld_viol++;
            if (mem_read_en && (m_occ + m_pend - int'(m_pop) >= 2)) cap_viol++;
            if (mem_read_en && m_pend > 0 && !mem_read_done) cap_viol++;
            if (have_prev && (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l)) stab_viol++;
            have_prev = out_valid && !out_ready; prev_d = out_data; prev_l = out_last;
            if (m_pop) begin got_d.push_back(out_data); got_l.push_back(out_last); last_pop_cyc = cyc; end
            if (mem_read_done && m_pend > 0) begin m_pend--; m_occ++; end
            if (m_pop) m_occ--;
            if (mem_read_en) m_pend++;
        end
    end

    task automatic fill(input bit rnd);
        exp_d.delete(); exp_l.delete();
        for (int i = 0; i < N; i++) mem_arr[i] = rnd ? W'($urandom) : W'(i);
        for (int r = 0; r < D0; r++)
            for (int c = 0; c < D1; c++) begin
                exp_d.push_back(mem_arr[r * D1 + c]);
                exp_l.push_back(r == D0 - 1 && c == D1 - 1);
            end
        mem_viol = 0; cap_viol = 0; stab_viol = 0; vld_viol = 0;
    endtask

    // hold: 0 = drop go mid-run then raise again, 1 = hold until done, 2 = leave go high
    task automatic run_drain(input int hold, output int dcyc, output int fvcyc, output int dabs);
        int t0;
        got_d.delete(); got_l.delete();
        dcyc = -1; fvcyc = -1; dabs = -1;
        @(posedge clk); #2;
        go = 1; t0 = cyc + 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (out_valid && fvcyc < 0) fvcyc = cyc - t0;
            if (done) begin dcyc = cyc - t0; dabs = cyc; break; end
            if (hold == 0) go = (i < 1 || i >= 4);
        end
        if (dcyc < 0) begin
            cmp++; mism++;
            $display("FAIL drain_timeout: done never rose, required within 400 cycles");
        end
        if (hold != 2) begin go = 0; @(negedge clk); end
    endtask

    task automatic test_reset();
        reset = 1; go = 0;
        repeat (2) @(negedge clk);
        cmp++; if (done !== 1'b0 || mem_read_en !== 1'b0) begin mism++;
            $display("FAIL reset_ctl: done=%b en=%b, required 0/0", done, mem_read_en); end
        cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin mism++;
            $display("FAIL reset_out: valid=%b last=%b data=%h, required 0", out_valid, out_last, out_data); end
        cmp++; if (mem_addr0 !== 4'd0 || mem_addr1 !== 4'd0) begin mism++;
            $display("FAIL reset_addr: %0d,%0d required 0,0", mem_addr0, mem_addr1); end
        @(posedge clk); #2 reset = 0;
        @(negedge clk);
        cmp++; if (mem_read_en !== 1'b0 || out_valid !== 1'b0) begin mism++;
            $display("FAIL idle_quiet: en=%b valid=%b without go, required 0/0", mem_read_en, out_valid); end
    endtask

    task automatic test_basic();
        int dc, fv, da;
        fill(0); lat = 1; rmode = 0;
        run_drain(1, dc, fv, da);
        cmp++; if (fv != 2) begin mism++; $display("FAIL basic_first_valid: %0d cycles, required 2", fv); end
        cmp++; if (dc != N + 2) begin mism++; $display("FAIL basic_done_time: %0d cycles, required %0d", dc, N + 2); end
        cmp++; if (got_d.size() != N) begin mism++; $display("FAIL basic_count: %0d words, required %0d", got_d.size(), N); end
        for (int i = 0; i < N && i < got_d.size(); i++) begin
            cmp++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin mism++;
                $display("FAIL basic_word[%0d]: %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        cmp++; if (cap_viol + vld_viol + mem_viol != 0) begin mism++;
            $display("FAIL basic_proto: cap=%0d vld=%0d mem=%0d, required 0", cap_viol, vld_viol, mem_viol); end
    endtask

    task automatic test_backpressure();
        int dc, fv, da;
        fill(1); lat = 1; rmode = 1;
        run_drain(1, dc, fv, da);
        cmp++; if (got_d.size() != N) begin mism++; $display("FAIL bp_count: %0d words, required %0d", got_d.size(), N); end
        for (int i = 0; i < N && i < got_d.size(); i++) begin
            cmp++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin mism++;
                $display("FAIL bp_word[%0d]: %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        cmp++; if (cap_viol != 0) begin mism++; $display("FAIL bp_capacity: %0d reads into full buffer, required 0", cap_viol); end
        cmp++; if (stab_viol != 0) begin mism++; $display("FAIL bp_stable: %0d changes while stalled, required 0", stab_viol); end
        cmp++; if (vld_viol + mem_viol != 0) begin mism++;
            $display("FAIL bp_proto: vld=%0d mem=%0d, required 0", vld_viol, mem_viol); end
        cmp++; if (da != last_pop_cyc) begin mism++; $display("FAIL bp_done_edge: done at %0d, last pop %0d", da, last_pop_cyc); end
    endtask

    task automatic test_latency3();
        int dc, fv, da;
        fill(0); lat = 3; rmode = 0;
        run_drain(1, dc, fv, da);
        for (int i = 0; i < N; i++) begin
            cmp++; if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin mism++;
                $display("FAIL lat3_word[%0d]: got %0d words, required %h/%b", i, got_d.size(), exp_d[i], exp_l[i]); end
        end
        cmp++; if (mem_viol + cap_viol != 0) begin mism++;
            $display("FAIL lat3_outstanding: mem=%0d cap=%0d, required 0", mem_viol, cap_viol); end
        cmp++; if (dc != 2 + 3 * N) begin mism++; $display("FAIL lat3_done_time: %0d cycles, required %0d", dc, 2 + 3 * N); end
        cmp++; if (da != last_pop_cyc) begin mism++; $display("FAIL lat3_done_edge: done at %0d, last pop %0d", da, last_pop_cyc); end
    endtask

    task automatic test_random();
        int dc, fv, da;
        for (int k = 0; k < 6; k++) begin
            fill(1); lat = $urandom_range(1, 4); rmode = 2;
            run_drain(int'($urandom_range(0, 1)), dc, fv, da);
            cmp++; if (got_d.size() != N) begin mism++;
                $display("FAIL rnd%0d_count: %0d words, required %0d", k, got_d.size(), N); end
            for (int i = 0; i < N && i < got_d.size(); i++) begin
                cmp++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin mism++;
                    $display("FAIL rnd%0d_word[%0d]: %h/%b required %h/%b", k, i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
            end
            cmp++; if (cap_viol + stab_viol + vld_viol + mem_viol != 0) begin mism++;
                $display("FAIL rnd%0d_proto: cap=%0d stab=%0d vld=%0d mem=%0d, required 0", k, cap_viol, stab_viol, vld_viol, mem_viol); end
            cmp++; if (da != last_pop_cyc) begin mism++;
                $display("FAIL rnd%0d_done_edge: done at %0d, last pop %0d", k, da, last_pop_cyc); end
        end
        rmode = 0;
    endtask

    task automatic test_reset_mid();
        int dc, fv, da;
        bit seen = 0;
        fill(1); lat = 1; rmode = 0;
        got_d.delete(); got_l.delete();
        @(posedge clk); #2 go = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (got_d.size() >= 3) begin seen = 1; break; end
        end
        cmp++; if (!seen) begin mism++; $display("FAIL rstmid_reach: %0d words before reset, required 3", got_d.size()); end
        reset = 1; go = 0;
        @(negedge clk);
        cmp++; if ({done, mem_read_en, out_valid, out_last, out_data, mem_addr0, mem_addr1} !== '0) begin mism++;
            $display("FAIL rstmid_zero: done=%b en=%b v=%b l=%b d=%h a=%0d,%0d, required all 0",
                     done, mem_read_en, out_valid, out_last, out_data, mem_addr0, mem_addr1); end
        @(posedge clk); #2 reset = 0;
        repeat (2) begin
            @(negedge clk);
            cmp++; if (out_valid !== 1'b0 || mem_read_en !== 1'b0 || done !== 1'b0) begin mism++;
                $display("FAIL rstmid_idle: v=%b en=%b done=%b, required 0", out_valid, mem_read_en, done); end
        end
        fill(1);
        run_drain(1, dc, fv, da);
        for (int i = 0; i < N; i++) begin
            cmp++; if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin mism++;
                $display("FAIL rstmid_word[%0d]: got %0d words, required %h/%b", i, got_d.size(), exp_d[i], exp_l[i]); end
        end
        cmp++; if (dc != N + 2) begin mism++; $display("FAIL rstmid_done_time: %0d cycles, required %0d", dc, N + 2); end
    endtask

    task automatic test_go_hold();
        int dc, fv, da;
        fill(1); lat = 1; rmode = 0;
        run_drain(2, dc, fv, da);
        repeat (4) begin
            @(negedge clk);
            cmp++; if (done !== 1'b1) begin mism++; $display("FAIL hold_done: %b while go high, required 1", done); end
        end
        go = 0; #1;
        cmp++; if (done !== 1'b0) begin mism++; $display("FAIL hold_drop: %b after go low, required 0", done); end
        @(negedge clk);
        cmp++; if (done !== 1'b0 || mem_read_en !== 1'b0 || out_valid !== 1'b0) begin mism++;
            $display("FAIL hold_idle: done=%b en=%b v=%b, required 0", done, mem_read_en, out_valid); end
        fill(0);
        run_drain(1, dc, fv, da);
        for (int i = 0; i < N; i++) begin
            cmp++; if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin mism++;
                $display("FAIL hold_word[%0d]: got %0d words, required %h/%b", i, got_d.size(), exp_d[i], exp_l[i]); end
        end
        cmp++; if (dc != N + 2) begin mism++; $display("FAIL hold_done_time: %0d cycles, required %0d", dc, N + 2); end
    endtask

`ifdef SEQ_MEM_DRAIN_TIMEOUT_EN
    task automatic test_timeout();
        int t0, ecyc = -1;
        fill(0); mute = 1; rmode = 0;
        @(posedge clk); #2 go = 1; t0 = cyc + 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err) begin ecyc = cyc - t0; break; end
        end
        cmp++; if (ecyc != TMO + 1) begin mism++; $display("FAIL tmo_time: err after %0d cycles, required %0d", ecyc, TMO + 1); end
        cmp++; if (done !== 1'b1 || out_valid !== 1'b0) begin mism++;
            $display("FAIL tmo_state: done=%b v=%b, required 1/0", done, out_valid); end
        go = 0; reset = 1; mute = 0;
        @(negedge clk); reset = 0;
        cmp++; if (err !== 1'b0) begin mism++; $display("FAIL tmo_clear: err=%b after reset, required 0", err); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1; go = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_latency3();
        test_random();
        test_reset_mid();
        test_go_hold();
`ifdef SEQ_MEM_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule

// File: doc/seq_mem_d2_drain.md
# seq_mem_d2_drain

Synthesizable drain engine for a `seq_mem_d2` memory. It acts as the read-side initiator on the memory's sequential read interface and walks the whole array in row-major order. Words are emitted on a valid/ready stream with a 2-entry buffer, so an on-chip consumer can unload results after `main` finishes, without simulation-only dumps.

## Interface
Parameters:
- `D0_SIZE`, 8: rows (outer index); must be ≥1.
- `D1_SIZE`, 8: columns (inner index); must be ≥1.
- `D0_IDX_SIZE`, 4: width of `mem_addr0`.
- `D1_IDX_SIZE`, 4: width of `mem_addr1`.
- `WIDTH`, 32: data width.
- `TIMEOUT`, 16: cycles to wait for `read_done`. Used only with `SEQ_MEM_DRAIN_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `go` in 1: start request, Calyx go/done convention.
- `done` out 1: drain complete.
- `mem_addr0` out D0_IDX_SIZE: row address to the memory.
- `mem_addr1` out D1_IDX_SIZE: column address to the memory.
- `mem_read_en` out 1: read request, one cycle per word.
- `mem_read_data` in WIDTH: memory read data, valid when `mem_read_done`=1.
- `mem_read_done` in 1: memory read completion.
- `out_valid` out 1: stream word available.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out WIDTH: stream word.
- `out_last` out 1: marks the final element (D0_SIZE-1, D1_SIZE-1).
- `err` out 1: timeout flag. Present only with `SEQ_MEM_DRAIN_TIMEOUT_EN`.

## Operation
- States:
  - IDLE: start when `go`=1.
  - RUN: issue reads and fill the buffer.
  - FLUSH: all reads issued; wait for the buffer to empty.
  - DONE: `done`=1 while `go`=1; move to IDLE when `go`=0.
- IDLE→RUN on `go`=1. The issue pointer (r,c) loads (0,0). `pending` and `count` load 0.
- Issue rule in RUN: assert `mem_read_en` with `mem_addr0`=r and `mem_addr1`=c when `count + pending - pop < 2`.
  - `pop` = `out_valid & out_ready` this cycle.
  - On issue, `pending` is set. At most one read is outstanding.
- A read may be issued in the same cycle that `mem_read_done` retires the previous one.
- On `mem_read_done`=1 with `pending`=1:
  - `mem_read_data` is pushed into the buffer.
  - The pushed word's last tag = (issued address was the final element).
  - `pending` clears unless a new read issues in the same cycle.
- `mem_read_done`=1 while `pending`=0, or in IDLE/DONE, is ignored.
- Pointer advance: c+1. When c wraps from D1_SIZE-1 to 0, r increments. After issuing (D0_SIZE-1, D1_SIZE-1), go to FLUSH.
- FLUSH→DONE when `pending`=0 and `count`=0.
- Buffer: 2-entry FIFO of {data, last}. `out_*` present the head. A simultaneous push and pop keeps `count` unchanged, and ordering is preserved.
- Stream rule: once `out_valid`=1, `out_data`/`out_last` hold stable until accepted.

## Timing
- Memory read latency is ≥1 cycle: `mem_read_done` arrives no earlier than the cycle after `mem_read_en`.
- With 1-cycle memory latency and `out_ready` held at 1:
  - One read is issued every cycle.
  - The first `out_valid` appears 2 cycles after `go` (IDLE→RUN, issue, push).
  - `done` rises D0_SIZE·D1_SIZE+2 cycles after `go` is sampled.
- `mem_read_en` is combinational from state, `count`, `pending` and `pop`. Addresses are registered.
- Reset values:
  - `done`, `mem_read_en`, `out_valid`, `out_last`, `err` = 0.
  - `out_data`, `mem_addr0`, `mem_addr1` = 0.
  - State = IDLE; `count` and `pending` = 0.
- Reset mid-drain returns immediately to IDLE and discards buffered words. A late `mem_read_done` is then ignored.
- `go` dropped during RUN/FLUSH is ignored; the drain completes.

## Configuration
- `SEQ_MEM_DRAIN_TIMEOUT_EN` defined:
  - A counter runs while `pending`=1 and clears on `mem_read_done`.
  - When it reaches TIMEOUT, `err` is set (sticky until reset) and the FSM goes to DONE.
  - The buffer is cleared and `out_valid` drops.
- Not defined: no counter and no `err` port. The engine waits indefinitely for `mem_read_done`.

## Test plan
- 2×3 memory holding 0..5, 1-cycle latency, `out_ready`=1 → stream 0,1,2,3,4,5; `out_last` only on 5; `done` 8 cycles after `go`.
- Same memory, `out_ready` toggling 1,0,0,1,… → no word lost or duplicated; `mem_read_en` never fires while `count + pending` = 2; data stays stable while stalled.
- Memory with 3-cycle read latency → at most one read outstanding; order 0..5 preserved; `done` after the last pop.
- `reset` asserted after the 3rd word, with a `mem_read_done` arriving the next cycle → all outputs 0, IDLE; a subsequent `go` drains from (0,0).
- `go` held high through DONE, then low → `done` stays 1 until `go`=0; a new `go` restarts cleanly.
- With `SEQ_MEM_DRAIN_TIMEOUT_EN`, the memory never asserts `mem_read_done` → `err`=1 and `done`=1 exactly TIMEOUT cycles after the issue.
